// File: rtl/adc_capture_sequencer.sv
// ---------------------------------------------------------------------------
// adc_capture_sequencer
//
// Sequences the ADC through power-on, settling, calibration, arming and a
// fixed-length capture. Driven by ASCII command bytes from the UART receiver
// and by an external trigger. Owns the ADC power, calibration and capture
// enable controls.
//
// Ports:
//   Clock         in   system clock, rising edge
//   Reset         in   synchronous, active-high
//   Cmd[7:0]      in   ASCII command byte
//   CmdValid      in   Cmd qualifier (single-cycle strobe)
//   TriggerIn     in   external trigger, synchronous level
//   SampleValid   in   ADC datapath has a sample this cycle
//   ADCPower      out  ADC power enable (every state except OFF)
//   ADCCal        out  calibration request (CAL only)
//   CaptureEnable out  capture write-enable gate (CAPTURE only)
//   Ready         out  powered, calibrated, idle (IDLE only)
//   Done          out  one-cycle pulse at capture completion (DONE only)
//   StateOut[2:0] out  current state code for debug/status readback
//
// Handshake: the command interface has no back-pressure. A byte is consumed
// on any rising edge where CmdValid=1; unrecognised bytes, or bytes with no
// meaning in the current state, are dropped without side effect.
// ---------------------------------------------------------------------------
module adc_capture_sequencer #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int CAL_CYCLES    = 64,
  parameter int CAPTURE_LEN   = 1024
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Cmd,
  input  logic       CmdValid,
  input  logic       TriggerIn,
  input  logic       SampleValid,
  output logic       ADCPower,
  output logic       ADCCal,
  output logic       CaptureEnable,
  output logic       Ready,
  output logic       Done,
  output logic [2:0] StateOut
);

  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_CAL     = 3'd2;
  localparam logic [2:0] ST_IDLE    = 3'd3;
  localparam logic [2:0] ST_ARMED   = 3'd4;
  localparam logic [2:0] ST_CAPTURE = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  // The cycle counter is shared by SETTLE and CAL, so it is sized for the
  // larger of the two durations.
  localparam int CNT_MAX = (SETTLE_CYCLES > CAL_CYCLES) ? SETTLE_CYCLES : CAL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int SW      = $clog2(CAPTURE_LEN + 1);

  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CAL_LAST     = CW'(CAL_CYCLES - 1);
  localparam logic [SW-1:0] CAPTURE_LAST = SW'(CAPTURE_LEN - 1);

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cyc_cnt, cyc_cnt_nxt;
  logic [SW-1:0] smp_cnt, smp_cnt_nxt;

  logic cmd_on, cmd_off, cmd_arm, cmd_disarm, cmd_trig;

  assign cmd_on     = CmdValid && (Cmd == 8'h4F); // 'O'
  assign cmd_off    = CmdValid && (Cmd == 8'h6F); // 'o'
  assign cmd_arm    = CmdValid && (Cmd == 8'h41); // 'A'
  assign cmd_disarm = CmdValid && (Cmd == 8'h61); // 'a'
  assign cmd_trig   = CmdValid && (Cmd == 8'h54); // 'T'

  // State and counter registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= ST_OFF;
      cyc_cnt <= '0;
      smp_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cyc_cnt_nxt;
      smp_cnt <= smp_cnt_nxt;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_nxt   = state;
    cyc_cnt_nxt = cyc_cnt;
    smp_cnt_nxt = smp_cnt;
    case (state)
      ST_OFF: begin
        if (cmd_on) begin
          state_nxt   = ST_SETTLE;
          cyc_cnt_nxt = '0;
        end
      end
      ST_SETTLE: begin
        if (cyc_cnt == SETTLE_LAST) begin
          state_nxt   = ST_CAL;
          cyc_cnt_nxt = '0;
        end else begin
          cyc_cnt_nxt = cyc_cnt + CW'(1);
        end
      end
      ST_CAL: begin
        if (cyc_cnt == CAL_LAST) begin
          state_nxt   = ST_IDLE;
          cyc_cnt_nxt = '0;
        end else begin
          cyc_cnt_nxt = cyc_cnt + CW'(1);
        end
      end
      ST_IDLE: begin
        if (cmd_arm) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        // Disarm wins over a coincident trigger.
        if (cmd_disarm) begin
          state_nxt = ST_IDLE;
        end else if (TriggerIn || cmd_trig) begin
          state_nxt   = ST_CAPTURE;
          smp_cnt_nxt = '0;
        end
      end
      ST_CAPTURE: begin
        if (SampleValid) begin
          smp_cnt_nxt = smp_cnt + SW'(1);
          if (smp_cnt == CAPTURE_LAST) state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // Returning to IDLE (not ARMED) means a held trigger cannot retrigger.
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_OFF;
      end
    endcase

    // Power-off overrides every transition above, including DONE, so an
    // aborted capture never pulses Done.
    if (cmd_off && (state != ST_OFF)) begin
      state_nxt   = ST_OFF;
      cyc_cnt_nxt = '0;
      smp_cnt_nxt = '0;
    end
  end

  // Moore output decode
  always_comb begin
    ADCPower      = (state != ST_OFF) && (state != 3'd7);
    ADCCal        = (state == ST_CAL);
    CaptureEnable = (state == ST_CAPTURE);
    Ready         = (state == ST_IDLE);
    Done          = (state == ST_DONE);
    StateOut      = state;
  end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
module tb_adc_capture_sequencer;

  logic       Clock;
  logic       Reset;
  logic [7:0] Cmd;
  logic       CmdValid;
  logic       TriggerIn;
  logic       SampleValid;
  logic       ADCPower;
  logic       ADCCal;
  logic       CaptureEnable;
  logic       Ready;
  logic       Done;
  logic [2:0] StateOut;

  int tests_run;
  int tests_failed;

  // Expected output bundles {ADCPower, ADCCal, CaptureEnable, Ready, Done}
  localparam logic [4:0] O_OFF  = 5'b00000;
  localparam logic [4:0] O_SETL = 5'b10000;
  localparam logic [4:0] O_CAL  = 5'b11000;
  localparam logic [4:0] O_IDLE = 5'b10010;
  localparam logic [4:0] O_ARM  = 5'b10000;
  localparam logic [4:0] O_CAP  = 5'b10100;
  localparam logic [4:0] O_DONE = 5'b10001;

  adc_capture_sequencer #(
    .SETTLE_CYCLES(8),
    .CAL_CYCLES   (4),
    .CAPTURE_LEN  (16)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Cmd          (Cmd),
    .CmdValid     (CmdValid),
    .TriggerIn    (TriggerIn),
    .SampleValid  (SampleValid),
    .ADCPower     (ADCPower),
    .ADCCal       (ADCCal),
    .CaptureEnable(CaptureEnable),
    .Ready        (Ready),
    .Done         (Done),
    .StateOut     (StateOut)
  );

  // Clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic [4:0] o);
    check({tag, " state"}, {5'd0, StateOut}, {5'd0, st});
    check({tag, " outs"},
          {3'd0, ADCPower, ADCCal, CaptureEnable, Ready, Done}, {3'd0, o});
  endtask

  // Driver: present one command byte for one edge.
  task automatic send_cmd(input logic [7:0] c);
    Cmd      = c;
    CmdValid = 1'b1;
    tick();
    CmdValid = 1'b0;
    Cmd      = 8'h00;
  endtask

  // 'O' then 8 settle + 4 cal edges lands in IDLE.
  task automatic power_up();
    send_cmd(8'h4F);
    repeat (12) tick();
    check_outs("power_up idle", 3'd3, O_IDLE);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Reset        = 1'b1;
    Cmd          = 8'h00;
    CmdValid     = 1'b0;
    TriggerIn    = 1'b0;
    SampleValid  = 1'b0;
    tick();
    tick();
    check_outs("reset", 3'd0, O_OFF);
    Reset = 1'b0;
    tick();
    check_outs("post reset", 3'd0, O_OFF);

    // 1. Power-up: SETTLE 8 cycles, CAL 4 cycles, then IDLE.
    send_cmd(8'h4F);
    check_outs("settle c1", 3'd1, O_SETL);
    for (int i = 2; i <= 8; i++) begin
      tick();
      check_outs($sformatf("settle c%0d", i), 3'd1, O_SETL);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_outs($sformatf("cal c%0d", i), 3'd2, O_CAL);
    end
    tick();
    check_outs("idle after cal", 3'd3, O_IDLE);

    // 2. Full capture with SampleValid on alternate cycles.
    send_cmd(8'h41);
    check_outs("armed", 3'd4, O_ARM);
    TriggerIn = 1'b1;
    tick();
    TriggerIn = 1'b0;
    check_outs("capture start", 3'd5, O_CAP);
    for (int k = 1; k <= 16; k++) begin
      SampleValid = 1'b1;
      tick();
      SampleValid = 1'b0;
      if (k < 16) begin
        check_outs($sformatf("cap beat%0d", k), 3'd5, O_CAP);
        tick();
        check_outs($sformatf("cap gap%0d", k), 3'd5, O_CAP);
      end
    end
    check_outs("done pulse", 3'd6, O_DONE);
    tick();
    check_outs("done to idle", 3'd3, O_IDLE);
    tick();
    check_outs("idle holds", 3'd3, O_IDLE);

    // 3a. Power-off during SETTLE (third settle cycle).
    send_cmd(8'h6F);
    check_outs("off from idle", 3'd0, O_OFF);
    send_cmd(8'h4F);
    tick();
    tick();
    check_outs("settle c3", 3'd1, O_SETL);
    send_cmd(8'h6F);
    check_outs("abort settle", 3'd0, O_OFF);
    tick();
    check_outs("abort settle hold", 3'd0, O_OFF);

    // 3b. Power-off on the 5th sample of a capture.
    power_up();
    send_cmd(8'h41);
    send_cmd(8'h54);
    check_outs("sw trig capture", 3'd5, O_CAP);
    for (int k = 1; k <= 4; k++) begin
      SampleValid = 1'b1;
      tick();
      SampleValid = 1'b0;
      tick();
    end
    check_outs("cap after 4", 3'd5, O_CAP);
    SampleValid = 1'b1;
    send_cmd(8'h6F);
    SampleValid = 1'b0;
    check_outs("abort capture", 3'd0, O_OFF);
    tick();
    check_outs("abort capture no done", 3'd0, O_OFF);

    // 4. Command filtering.
    send_cmd(8'h41);
    check_outs("A in off", 3'd0, O_OFF);
    power_up();
    send_cmd(8'h54);
    check_outs("T in idle", 3'd3, O_IDLE);
    send_cmd(8'h4F);
    check_outs("O in idle", 3'd3, O_IDLE);
    tick();
    check_outs("O in idle hold", 3'd3, O_IDLE);
    send_cmd(8'h55);
    check_outs("0x55 in idle", 3'd3, O_IDLE);
    Cmd = 8'h41;
    tick();
    Cmd = 8'h00;
    check_outs("A without valid", 3'd3, O_IDLE);
    TriggerIn = 1'b1;
    tick();
    TriggerIn = 1'b0;
    check_outs("trigger in idle", 3'd3, O_IDLE);

    // 5. Disarm beats trigger; held trigger yields one capture.
    send_cmd(8'h41);
    check_outs("armed 2", 3'd4, O_ARM);
    Cmd       = 8'h61;
    CmdValid  = 1'b1;
    TriggerIn = 1'b1;
    tick();
    Cmd       = 8'h00;
    CmdValid  = 1'b0;
    TriggerIn = 1'b0;
    check_outs("disarm wins", 3'd3, O_IDLE);
    tick();
    check_outs("disarm hold", 3'd3, O_IDLE);
    send_cmd(8'h41);
    TriggerIn = 1'b1;
    tick();
    check_outs("held trig capture", 3'd5, O_CAP);
    SampleValid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) check_outs($sformatf("held beat%0d", k), 3'd5, O_CAP);
      else        check_outs("held done", 3'd6, O_DONE);
    end
    SampleValid = 1'b0;
    tick();
    check_outs("held back idle", 3'd3, O_IDLE);
    tick();
    tick();
    check_outs("held no retrigger", 3'd3, O_IDLE);
    TriggerIn = 1'b0;

    // 6. Reset mid-capture, then a full settle again.
    send_cmd(8'h41);
    send_cmd(8'h54);
    check_outs("capture for reset", 3'd5, O_CAP);
    SampleValid = 1'b1;
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    Reset       = 1'b0;
    SampleValid = 1'b0;
    check_outs("reset mid capture", 3'd0, O_OFF);
    send_cmd(8'h4F);
    check_outs("resettle c1", 3'd1, O_SETL);
    repeat (7) tick();
    check_outs("resettle c8", 3'd1, O_SETL);
    tick();
    check_outs("recal c1", 3'd2, O_CAL);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
